// File: rtl/mux_arbiter32_pkg.sv
// Shared constants and FSM encoding for the 32-way round-robin grant arbiter.
package mux_arbiter32_pkg;

    localparam int unsigned N_REQ  = 32;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mux_arbiter32_decoder5to32.sv
// Plain 5-to-32 one-hot address decoder.
module decoder5to32
    import mux_arbiter32_pkg::*;
(
    input  logic [SEL_W-1:0] addr_i,
    output logic [N_REQ-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        dec_o[addr_i] = 1'b1;
    end

endmodule

// File: rtl/mux_arbiter32_rr_pick32.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module rr_pick32
    import mux_arbiter32_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] win_o,
    output logic             any_o
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // 5-bit addition wraps 31 -> 0 for free
            idx = ptr_i + SEL_W'(i);
            if (!found && req_i[idx]) begin
                win_o = idx;
                found = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/mux_arbiter32.sv
// 32-requester round-robin arbiter with a bounded hold time and timeout pulse.
module mux_arbiter32
    import mux_arbiter32_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] S,
    output logic             VALID,
    output logic             TOUT
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              tout_q, tout_d;

    logic [SEL_W-1:0]  win;
    logic              any_req;
    logic [N_REQ-1:0]  dec;
    logic              hold_hit;

    rr_pick32 u_pick (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any_req)
    );

    decoder5to32 u_dec (
        .addr_i (s_q),
        .dec_o  (dec)
    );

    assign hold_hit = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    s_d     = win;
                    ptr_d   = win + SEL_W'(1);
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (DONE || !REQ[s_q] || hold_hit) begin
                    state_d = IDLE;
                    // DONE or a dropped request wins over the counter
                    tout_d  = hold_hit && !DONE && REQ[s_q];
                end else if (!hold_hit) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign VALID = (state_q == BUSY);
    assign S     = s_q;
    assign GNT   = dec & {N_REQ{VALID}};
    assign TOUT  = tout_q;

endmodule

// File: doc/mux_arbiter32.md
MUX_ARBITER32 -- requirements
Module: mux_arbiter32

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum cycles one grant may be held before forced release (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port REQ  input  32  per-requester request, level-sensitive, bit i = requester i.
REQ-005 SHALL have port DONE  input  1  release strobe from the currently granted requester.
REQ-006 SHALL have port GNT  output  32  one-hot grant, registered; all-zero when no grant.
REQ-007 SHALL have port S  output  5  binary index of granted requester, registered; drives the 32:1 mux select and the 5-to-32 decoder address.
REQ-008 SHALL have port VALID  output  1  high while a grant is active; qualifies S.
REQ-009 SHALL have port TOUT  output  1  one-cycle pulse when a grant is forcibly released by timeout.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-011 IDLE: if REQ != 0, SHALL select the winner by round-robin and enter BUSY on the next edge; if REQ == 0, SHALL remain in IDLE.
REQ-012 Round-robin SHALL search from index PTR upward, modulo 32, wrapping from 31 to 0; the first set REQ bit wins.
REQ-013 PTR SHALL be updated to (winner+1) mod 32 when the grant is issued; a winner of 31 SHALL set PTR to 0.
REQ-014 Latency SHALL be one cycle: REQ sampled in IDLE at edge n gives GNT, S and VALID valid after edge n.
REQ-015 In BUSY, GNT SHALL equal the 5-to-32 decode of S, and S SHALL be stable for the whole grant.
REQ-016 BUSY SHALL exit to IDLE on the first edge where any release condition holds: DONE=1, REQ[S]=0, or hold counter = MAX_HOLD-1.
REQ-017 Hold counter SHALL be 8 bits, cleared on grant issue and incremented every BUSY cycle, saturating at MAX_HOLD-1.
REQ-018 TOUT SHALL pulse for exactly one cycle only when the exit is caused by the counter with DONE=0 and REQ[S]=1; DONE on the same edge takes precedence and gives no TOUT.
REQ-019 On exit from BUSY, GNT SHALL be 0, VALID 0 and S held at its last value; at least one IDLE cycle SHALL separate consecutive grants.
REQ-020 DONE SHALL be ignored in IDLE; REQ changes other than REQ[S] SHALL be ignored in BUSY.
REQ-021 A requester that holds REQ high after release SHALL not win again while any other requester is requesting (fairness bound: 31 intervening grants).

Reset
REQ-022 While reset is high, the block SHALL force: state=IDLE, PTR=0, hold counter=0, GNT=0, S=0, VALID=0, TOUT=0.
REQ-023 Reset asserted mid-grant SHALL drop GNT and VALID immediately (asynchronously), with no TOUT.
REQ-024 First arbitration after reset release SHALL start the search at index 0.

Structure
REQ-025 Shared package SHALL hold: N_REQ=32, SEL_W=5, the FSM state encoding (IDLE=0, BUSY=1), and HOLD_W=8.
REQ-026 Round-robin search SHALL be a sub-module rr_pick32 (inputs REQ, PTR; outputs winner index and any-request flag), purely combinational.
REQ-027 GNT SHALL be produced by instantiating the team's existing decoder5to32 on the registered S, gated with VALID.

Verification
REQ-028 Reset, then REQ=0x0000_0001 -> after 1 edge GNT=0x0000_0001, S=0, VALID=1; after DONE, GNT=0 and PTR=1.
REQ-029 REQ=0xFFFF_FFFF held, DONE pulsed in every BUSY cycle -> S sequence 0,1,2,...,31,0 with one IDLE cycle between grants.
REQ-030 PTR=31, REQ=0x8000_0001 -> grant to 31, then to 0 (wrap), then to 31.
REQ-031 MAX_HOLD=4, REQ[5] held, no DONE -> VALID high exactly 4 cycles, TOUT pulses once on the exit edge.
REQ-032 Grant to 7 active, REQ[7] dropped mid-grant -> release on the next edge with TOUT=0; DONE together with the timeout edge -> TOUT=0.
REQ-033 Reset asserted during BUSY -> GNT=0, VALID=0 with no clock edge; after release, the next grant goes to the lowest requesting index.
